// File: rtl/cam_pattern_tx.sv
// Synthetic OV7670-style DVP transmitter: pclk = i_clk/2, RGB565 high byte first, frame-synchronous patterns.
// Define CAM_PATTERN_CRC_EN to add a per-frame CRC-16-CCITT over active bytes (o_crc/o_crc_valid).
module cam_pattern_tx #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 784,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 510
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [1:0]  i_pattern,
    input  logic [15:0] i_solid,
    output logic        o_cam_pclk,
    output logic        o_cam_vsync,
    output logic        o_cam_href,
    output logic [7:0]  o_cam_data,
    output logic        o_sof,
    output logic        o_busy
`ifdef CAM_PATTERN_CRC_EN
    ,
    output logic [15:0] o_crc,
    output logic        o_crc_valid
`endif
);

    localparam int H_W   = $clog2(2 * H_TOTAL + 1);
    localparam int V_W   = $clog2(V_TOTAL + 1);
    localparam int BAR_W = $clog2(H_ACTIVE / 8 + 1);

    localparam logic [H_W-1:0]   H_LAST     = H_W'(2 * H_TOTAL - 1);
    localparam logic [H_W-1:0]   H_ACT_END  = H_W'(2 * H_ACTIVE);
    localparam logic [H_W-1:0]   H_ONE      = H_W'(1);
    localparam logic [V_W-1:0]   V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0]   V_SYNC_END = V_W'(V_SYNC);
    localparam logic [V_W-1:0]   V_ACT_BEG  = V_W'(V_SYNC + V_BACK);
    localparam logic [V_W-1:0]   V_ACT_END  = V_W'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic [V_W-1:0]   V_ONE      = V_W'(1);
    localparam logic [BAR_W-1:0] BAR_LAST   = BAR_W'(H_ACTIVE / 8 - 1);
    localparam logic [BAR_W-1:0] BAR_ONE    = BAR_W'(1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = 16'hFFFF;
            3'd1:    c = 16'hFFE0;
            3'd2:    c = 16'h07FF;
            3'd3:    c = 16'h07E0;
            3'd4:    c = 16'hF81F;
            3'd5:    c = 16'hF800;
            3'd6:    c = 16'h001F;
            default: c = 16'h0000;
        endcase
        return c;
    endfunction

    state_t           state_q;
    logic             pclk_q;
    logic [H_W-1:0]   h_q;
    logic [V_W-1:0]   v_q;
    logic [2:0]       bar_q;
    logic [BAR_W-1:0] inbar_q;
    logic [1:0]       pat_q;
    logic [15:0]      solid_q;
    logic             vsync_q;
    logic             href_q;
    logic [7:0]       data_q;
    logic             sof_q;
    logic             busy_q;

    logic             run_tick;
    logic             h_wrap;
    logic             v_wrap;
    logic             frame_end;
    logic             start_frame;
    logic [V_W-1:0]   y_lin;
    logic [5:0]       x_hi;
    logic             x_b5;
    logic             y_b5;
    logic [15:0]      pix;
    logic             vsync_d;
    logic             href_d;
    logic [7:0]       data_d;

    always_comb begin
        run_tick    = pclk_q && (state_q == S_RUN);
        h_wrap      = (h_q == H_LAST);
        v_wrap      = (v_q == V_LAST);
        frame_end   = run_tick && h_wrap && v_wrap;
        start_frame = i_enable && ((pclk_q && (state_q == S_IDLE)) || frame_end);

        // x = h>>1, so x[7:2] = h[8:3] and x[5] = h[6]
        x_hi  = 6'(h_q >> 3);
        x_b5  = 1'(h_q >> 6);
        y_lin = v_q - V_ACT_BEG;
        y_b5  = 1'(y_lin >> 5);

        pix = 16'h0000;
        case (pat_q)
            2'd0:    pix = bar_colour(bar_q);
            2'd1:    pix = {x_hi[5:1], x_hi, x_hi[5:1]};
            2'd2:    pix = solid_q;
            default: pix = (x_b5 ^ y_b5) ? 16'hFFFF : 16'h0000;
        endcase

        vsync_d = (v_q < V_SYNC_END);
        href_d  = (v_q >= V_ACT_BEG) && (v_q < V_ACT_END) && (h_q < H_ACT_END);
        data_d  = href_d ? (h_q[0] ? pix[7:0] : pix[15:8]) : 8'h00;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            pclk_q  <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            bar_q   <= '0;
            inbar_q <= '0;
            pat_q   <= '0;
            solid_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            data_q  <= 8'h00;
            sof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            pclk_q <= ~pclk_q;
            sof_q  <= start_frame;

            if (start_frame) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                pat_q   <= i_pattern;
                solid_q <= i_solid;
                h_q     <= '0;
                v_q     <= '0;
                bar_q   <= '0;
                inbar_q <= '0;
            end

            // Outputs and counters move only on the edge where pclk falls
            if (run_tick) begin
                vsync_q <= vsync_d;
                href_q  <= href_d;
                data_q  <= data_d;
                if (h_wrap) begin
                    h_q     <= '0;
                    bar_q   <= '0;
                    inbar_q <= '0;
                    v_q     <= v_wrap ? '0 : v_q + V_ONE;
                end else begin
                    h_q <= h_q + H_ONE;
                    if (h_q[0]) begin
                        if (inbar_q == BAR_LAST) begin
                            inbar_q <= '0;
                            bar_q   <= bar_q + 3'd1;
                        end else begin
                            inbar_q <= inbar_q + BAR_ONE;
                        end
                    end
                end
                if (frame_end && !i_enable) begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    vsync_q <= 1'b0;
                    href_q  <= 1'b0;
                    data_q  <= 8'h00;
                end
            end
        end
    end

    assign o_cam_pclk  = pclk_q;
    assign o_cam_vsync = vsync_q;
    assign o_cam_href  = href_q;
    assign o_cam_data  = data_q;
    assign o_sof       = sof_q;
    assign o_busy      = busy_q;

`ifdef CAM_PATTERN_CRC_EN
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            c = (c[15] ^ b[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] crc_q;
    logic [15:0] crc_out_q;
    logic        crc_valid_q;
    logic [15:0] crc_nxt;
    logic        last_act;

    always_comb begin
        crc_nxt  = crc16_byte(crc_q, data_d);
        last_act = (h_q == H_ACT_END - H_ONE) && (v_q == V_ACT_END - V_ONE);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            crc_q       <= 16'h0000;
            crc_out_q   <= 16'h0000;
            crc_valid_q <= 1'b0;
        end else begin
            crc_valid_q <= 1'b0;
            if (start_frame) begin
                crc_q <= 16'hFFFF;
            end else if (run_tick && href_d) begin
                crc_q <= crc_nxt;
                if (last_act) begin
                    crc_out_q   <= crc_nxt;
                    crc_valid_q <= 1'b1;
                end
            end
        end
    end

    assign o_crc       = crc_out_q;
    assign o_crc_valid = crc_valid_q;
`endif

endmodule

// File: tb/tb_cam_pattern_tx.sv
// Directed bench for cam_pattern_tx: a DVP receiver captures each frame on pclk rising edges,
// then hand-computed bytes, timings and control behaviour are asserted.
module tb_cam_pattern_tx;

    localparam int HA = 64, HT = 66, VS = 1, VB = 2, VA = 36, VT = 40;
    localparam int FRAME_CLKS = 4 * HT * VT;
    localparam int LINE_BYTES = 2 * HA;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [1:0]  pat;
    logic [15:0] solid;
    logic        pclk, vsync, href, sof, busy;
    logic [7:0]  data;
`ifdef CAM_PATTERN_CRC_EN
    logic [15:0] crc;
    logic        crc_valid;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cam_pattern_tx #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_TOTAL(VT)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (en),
        .i_pattern  (pat),
        .i_solid    (solid),
        .o_cam_pclk (pclk),
        .o_cam_vsync(vsync),
        .o_cam_href (href),
        .o_cam_data (data),
        .o_sof      (sof),
        .o_busy     (busy)
`ifdef CAM_PATTERN_CRC_EN
        ,
        .o_crc      (crc),
        .o_crc_valid(crc_valid)
`endif
    );

    // Receiver: samples on pclk rising, as a capture block would
    logic [7:0] cap [VA][LINE_BYTES];
    int   line_len [VA];
    int   rx_line = 0, rx_col = 0, vs_run = 0, vs_len = 0, glitch_errs = 0, crc_pulses = 0;
    logic rx_href_prev = 1'b0, pclk_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(negedge clk) begin
        if (pclk && !pclk_prev) begin
            if (data !== data_prev) glitch_errs++;
            if (vsync) begin
                vs_run++;
                rx_line = 0;
                rx_col  = 0;
            end else begin
                if (vs_run != 0) begin
                    vs_len = vs_run;
                    vs_run = 0;
                end
                if (href) begin
                    if (rx_line < VA && rx_col < LINE_BYTES) cap[rx_line][rx_col] = data;
                    rx_col++;
                end else if (rx_href_prev) begin
                    if (rx_line < VA) line_len[rx_line] = rx_col;
                    rx_line++;
                    rx_col = 0;
                end
            end
            rx_href_prev = href;
        end
        pclk_prev = pclk;
        data_prev = data;
`ifdef CAM_PATTERN_CRC_EN
        if (crc_valid) crc_pulses++;
`endif
    end

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    int          gx [5] = '{0, 4, 8, 33, 63};
    logic [15:0] gp [5] = '{16'h0000, 16'h0020, 16'h0841, 16'h2104, 16'h39E7};
    int          cy [7] = '{0, 0, 0, 31, 32, 32, 35};
    int          cx [7] = '{0, 31, 32, 63, 0, 32, 63};
    logic [15:0] cp [7] = '{16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sof(input string tag, input int limit, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!sof && cycles < limit);
        chk(tag, 32'(sof), 32'd1);
    endtask

    function automatic logic [7:0] pix_byte(input logic [15:0] p, input int col);
        return (col % 2 == 1) ? p[7:0] : p[15:8];
    endfunction

    task automatic check_frame_shape(input string tag);
        int bad_len;
        bad_len = 0;
        for (int l = 0; l < VA; l++) if (line_len[l] != LINE_BYTES) bad_len++;
        chk({tag, "_lines"}, 32'(rx_line), 32'(VA));
        chk({tag, "_line_len"}, 32'(bad_len), 32'd0);
        chk({tag, "_vsync_pclks"}, 32'(vs_len), 32'(2 * HT));
        chk({tag, "_glitches"}, 32'(glitch_errs), 32'd0);
    endtask

`ifdef CAM_PATTERN_CRC_EN
    function automatic logic [15:0] sw_crc(input logic [15:0] c_in, input logic [7:0] b);
        logic [15:0] c;
        c = c_in ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
        return c;
    endfunction
`endif

    initial begin
        int gap, cnt, extra_sof, pulses_c, n_vs, n_hr;
        logic [15:0] ref_crc;
        rst = 1'b1; en = 1'b0; pat = 2'd0; solid = 16'h0000;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_pclk", 32'(pclk), 32'd0);
        chk("rst_vsync", 32'(vsync), 32'd0);
        chk("rst_href", 32'(href), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_sof", 32'(sof), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef CAM_PATTERN_CRC_EN
        chk("rst_crc", 32'(crc), 32'd0);
        chk("rst_crc_valid", 32'(crc_valid), 32'd0);
`endif
        rst = 1'b0;
        @(negedge clk); chk("pclk_t1", 32'(pclk), 32'd1);
        @(negedge clk); chk("pclk_t2", 32'(pclk), 32'd0);
        @(negedge clk); chk("pclk_t3", 32'(pclk), 32'd1);
        @(negedge clk); chk("pclk_t4", 32'(pclk), 32'd0);
        chk("idle_vsync", 32'(vsync), 32'd0);
        chk("idle_href", 32'(href), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // Frame A: colour bars; grey requested for the following frame
        en = 1'b1; pat = 2'd0;
        wait_sof("sof_A", 10, gap);
        chk("busy_at_sof_A", 32'(busy), 32'd1);
        pat = 2'd1;
        wait_sof("sof_B", FRAME_CLKS + 20, gap);
        chk("gap_AB", 32'(gap), 32'(FRAME_CLKS));
        check_frame_shape("A");
        for (int l = 0; l < VA; l += VA - 1)
            for (int c = 0; c < LINE_BYTES; c++)
                chk($sformatf("bars_l%0d_c%0d", l, c), 32'(cap[l][c]), 32'(pix_byte(bars[c / 16], c)));

        // Frame B: grey ramp; solid 0x1234 requested next
        pat = 2'd2; solid = 16'h1234;
        wait_sof("sof_C", FRAME_CLKS + 20, gap);
        chk("gap_BC", 32'(gap), 32'(FRAME_CLKS));
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("grey_x%0d_hi", gx[i]), 32'(cap[5][2 * gx[i]]), 32'(gp[i][15:8]));
            chk($sformatf("grey_x%0d_lo", gx[i]), 32'(cap[5][2 * gx[i] + 1]), 32'(gp[i][7:0]));
        end
        pulses_c = crc_pulses;

        // Frame C: solid; switch to checkerboard mid-frame
        repeat (FRAME_CLKS / 2) @(negedge clk);
        pat = 2'd3; solid = 16'hABCD;
        wait_sof("sof_D", FRAME_CLKS + 20, gap);
        chk("gap_CD_mid_switch", 32'(gap), 32'(FRAME_CLKS / 2));
        for (int l = 0; l < VA; l += VA - 1)
            for (int c = 0; c < LINE_BYTES; c++)
                chk($sformatf("solid_l%0d_c%0d", l, c), 32'(cap[l][c]), 32'(pix_byte(16'h1234, c)));
`ifdef CAM_PATTERN_CRC_EN
        ref_crc = 16'hFFFF;
        for (int l = 0; l < VA; l++)
            for (int c = 0; c < LINE_BYTES; c++) ref_crc = sw_crc(ref_crc, cap[l][c]);
        chk("crc_frame_C", 32'(crc), 32'(ref_crc));
        chk("crc_pulses_C", 32'(crc_pulses - pulses_c), 32'd1);
`else
        ref_crc = 16'h0000;
        chk("crc_absent_pulses", 32'(crc_pulses - pulses_c + 32'(ref_crc)), 32'd0);
`endif

        // Frame D: checkerboard; enable dropped mid-frame must not truncate it
        cnt = 0; extra_sof = 0;
        repeat (FRAME_CLKS / 2) begin
            @(negedge clk); cnt++;
            if (sof) extra_sof++;
        end
        en = 1'b0;
        while (busy && cnt < FRAME_CLKS + 20) begin
            @(negedge clk); cnt++;
            if (sof) extra_sof++;
        end
        chk("busy_fall_cycle", 32'(cnt), 32'(FRAME_CLKS));
        chk("busy_low_after", 32'(busy), 32'd0);
        chk("sof_during_D", 32'(extra_sof), 32'd0);
        check_frame_shape("D");
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("chk_y%0d_x%0d_hi", cy[i], cx[i]), 32'(cap[cy[i]][2 * cx[i]]), 32'(cp[i][15:8]));
            chk($sformatf("chk_y%0d_x%0d_lo", cy[i], cx[i]), 32'(cap[cy[i]][2 * cx[i] + 1]), 32'(cp[i][7:0]));
        end
        extra_sof = 0; n_vs = 0; n_hr = 0;
        repeat (300) begin
            @(negedge clk);
            if (sof) extra_sof++;
            if (vsync) n_vs++;
            if (href || data != 8'h00) n_hr++;
        end
        chk("idle_no_sof", 32'(extra_sof), 32'd0);
        chk("idle_no_vsync", 32'(n_vs), 32'd0);
        chk("idle_no_href_data", 32'(n_hr), 32'd0);

        // Frame E: reset asserted in the middle of an active line
        en = 1'b1; pat = 2'd0;
        wait_sof("sof_E", 10, gap);
        repeat (FRAME_CLKS / 2 + 40) @(negedge clk);
        chk("href_mid_E", 32'(href), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_pclk", 32'(pclk), 32'd0);
        chk("midrst_vsync", 32'(vsync), 32'd0);
        chk("midrst_href", 32'(href), 32'd0);
        chk("midrst_data", 32'(data), 32'd0);
        chk("midrst_sof", 32'(sof), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0; en = 1'b0;
        extra_sof = 0; n_hr = 0;
        repeat (20) begin
            @(negedge clk);
            if (sof || busy) extra_sof++;
            if (vsync || href || data != 8'h00) n_hr++;
        end
        chk("post_rst_idle", 32'(extra_sof), 32'd0);
        chk("post_rst_outputs", 32'(n_hr), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
